// File: rtl/rx_idle_monitor.sv
// rtl/rx_idle_monitor.sv - receive-side idle ordered-set checker and lane-alignment FSM
//
// Purpose: classifies decoded 8B/10B symbols as idle /K/ (K28.5), /A/ (K28.3),
// /R/ (K28.0), data or illegal; runs the HUNT/VERIFY/ALIGNED alignment FSM;
// checks "/K/ first after data" and /A/ spacing; counts errors per window and
// drops the lane at the error limit. User data is only flagged while aligned.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   rx_valid     symbol strobe from the decoder
//   rx_char      decoded character
//   rx_is_k      character is a K code
//   rx_code_err  disparity/code violation on this symbol
//   lane_up      lane aligned
//   data_out     last sampled character (registered)
//   data_valid   data_out holds a user data symbol
//   got_K/A/R    one-cycle pulse per classified idle symbol
//   err          one-cycle pulse on any detected error (not in HUNT)
//   err_count    (RX_IDLE_STATS_EN only) saturating total of err pulses
//
// Build option: define RX_IDLE_STATS_EN to add the err_count output.
module rx_idle_monitor #(
  parameter int VERIFY_CNT = 8,
  parameter int A_MIN_GAP  = 17,
  parameter int A_MAX_GAP  = 32,
  parameter int ERR_LIMIT  = 4,
  parameter int ERR_WINDOW = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_char,
  input  logic        rx_is_k,
  input  logic        rx_code_err,
  output logic        lane_up,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        got_K,
  output logic        got_A,
  output logic        got_R,
  output logic        err
`ifdef RX_IDLE_STATS_EN
  ,
  output logic [15:0] err_count
`endif
);

  localparam int GAP_SAT = 63;
  localparam int VW = $clog2(VERIFY_CNT + 1);
  localparam int GW = $clog2(GAP_SAT + 1);
  localparam int WW = $clog2(ERR_WINDOW + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);

  localparam logic [7:0]    CHAR_K        = 8'hBC;
  localparam logic [7:0]    CHAR_A        = 8'h7C;
  localparam logic [7:0]    CHAR_R        = 8'h1C;
  localparam logic [VW-1:0] VERIFY_TARGET = VW'(VERIFY_CNT);
  localparam logic [GW:0]   MIN_GAP_L     = (GW+1)'(A_MIN_GAP);
  localparam logic [GW-1:0] MAX_GAP_L     = GW'(A_MAX_GAP);
  localparam logic [GW-1:0] GAP_SAT_L     = GW'(GAP_SAT);
  localparam logic [WW-1:0] WINDOW_L      = WW'(ERR_WINDOW);
  localparam logic [EW-1:0] LIMIT_L       = EW'(ERR_LIMIT);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    VERIFY  = 2'd1,
    ALIGNED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          armed_q, armed_d;
  logic          need_k_q, need_k_d;
  logic [WW-1:0] win_q, win_d;
  logic [EW-1:0] ecnt_q, ecnt_d;

  logic          err_d, data_valid_d, got_k_d, got_a_d, got_r_d;
  logic [7:0]    data_out_d;
  logic          go_hunt;

  // Symbol classification; a code error overrides everything else.
  logic sym_k, sym_a, sym_r, sym_idle, sym_data, sym_bad;
  assign sym_k    = rx_is_k && !rx_code_err && (rx_char == CHAR_K);
  assign sym_a    = rx_is_k && !rx_code_err && (rx_char == CHAR_A);
  assign sym_r    = rx_is_k && !rx_code_err && (rx_char == CHAR_R);
  assign sym_idle = sym_k || sym_a || sym_r;
  assign sym_data = !rx_is_k && !rx_code_err;
  assign sym_bad  = !sym_idle && !sym_data;

  // gap_q counts symbols since the last /A/, so gap_q+1 is the distance from it.
  logic [GW:0] gap_dist;
  assign gap_dist = {1'b0, gap_q} + (GW+1)'(1);

  logic seq_err, amin_err, amax_err, rule_err;
  assign seq_err  = need_k_q && sym_idle && !sym_k;
  assign amin_err = sym_a && armed_q && (gap_dist < MIN_GAP_L);
  // Fires only on the symbol where the distance first exceeds the maximum;
  // the counter then moves past MAX_GAP_L (and saturates above it).
  assign amax_err = !sym_a && !sym_data && armed_q && (gap_q == MAX_GAP_L);
  assign rule_err = seq_err || amin_err || amax_err;

  logic [VW-1:0] vcnt_inc;
  logic [WW-1:0] win_inc;
  assign vcnt_inc = vcnt_q + VW'(1);
  assign win_inc  = win_q + WW'(1);

  always_comb begin
    state_d      = state_q;
    vcnt_d       = vcnt_q;
    gap_d        = gap_q;
    armed_d      = armed_q;
    need_k_d     = need_k_q;
    win_d        = win_q;
    ecnt_d       = ecnt_q;
    err_d        = 1'b0;
    data_valid_d = 1'b0;
    got_k_d      = 1'b0;
    got_a_d      = 1'b0;
    got_r_d      = 1'b0;
    data_out_d   = data_out;
    go_hunt      = 1'b0;

    if (rx_valid) begin
      got_k_d      = sym_k;
      got_a_d      = sym_a;
      got_r_d      = sym_r;
      data_out_d   = rx_char;
      err_d        = (state_q != HUNT) && (sym_bad || rule_err);
      data_valid_d = sym_data && (state_q == ALIGNED);

      // Idle-run tracking: data ends a run, disarms the /A/ check and
      // demands /K/ as the next idle symbol.
      if (sym_a) begin
        gap_d = '0;
      end else if (gap_q != GAP_SAT_L) begin
        gap_d = gap_q + GW'(1);
      end
      if (sym_data) begin
        armed_d  = 1'b0;
        need_k_d = 1'b1;
      end else if (sym_idle) begin
        need_k_d = 1'b0;
        if (sym_a) begin
          armed_d = 1'b1;
        end
      end

      case (state_q)
        HUNT: begin
          gap_d    = '0;
          armed_d  = 1'b0;
          need_k_d = 1'b0;
          if (sym_k) begin
            state_d = VERIFY;
            vcnt_d  = VW'(1);
          end
        end
        VERIFY: begin
          if (sym_idle && !rule_err) begin
            if (vcnt_inc == VERIFY_TARGET) begin
              state_d = ALIGNED;
              vcnt_d  = '0;
            end else begin
              vcnt_d = vcnt_inc;
            end
          end else begin
            go_hunt = 1'b1;
          end
        end
        ALIGNED: begin
          if (win_inc == WINDOW_L) begin
            // An error on the wrapping symbol belongs to the new window.
            win_d  = '0;
            ecnt_d = err_d ? EW'(1) : '0;
          end else begin
            win_d = win_inc;
            if (err_d && (ecnt_q != LIMIT_L)) begin
              ecnt_d = ecnt_q + EW'(1);
            end
          end
          if (ecnt_d == LIMIT_L) begin
            go_hunt = 1'b1;
          end
        end
        default: go_hunt = 1'b1;
      endcase

      if (go_hunt) begin
        state_d  = HUNT;
        vcnt_d   = '0;
        gap_d    = '0;
        armed_d  = 1'b0;
        need_k_d = 1'b0;
        win_d    = '0;
        ecnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vcnt_q     <= '0;
      gap_q      <= '0;
      armed_q    <= 1'b0;
      need_k_q   <= 1'b0;
      win_q      <= '0;
      ecnt_q     <= '0;
      lane_up    <= 1'b0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      got_K      <= 1'b0;
      got_A      <= 1'b0;
      got_R      <= 1'b0;
      err        <= 1'b0;
    end else begin
      vcnt_q     <= vcnt_d;
      gap_q      <= gap_d;
      armed_q    <= armed_d;
      need_k_q   <= need_k_d;
      win_q      <= win_d;
      ecnt_q     <= ecnt_d;
      lane_up    <= (state_d == ALIGNED);
      data_out   <= data_out_d;
      data_valid <= data_valid_d;
      got_K      <= got_k_d;
      got_A      <= got_a_d;
      got_R      <= got_r_d;
      err        <= err_d;
    end
  end

`ifdef RX_IDLE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_d && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rx_idle_monitor.sv
// tb/tb_rx_idle_monitor.sv - directed self-checking bench for rx_idle_monitor
module tb_rx_idle_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_char;
  logic        rx_is_k;
  logic        rx_code_err;
  logic        lane_up;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        got_K;
  logic        got_A;
  logic        got_R;
  logic        err;
`ifdef RX_IDLE_STATS_EN
  logic [15:0] err_count;
`endif

  int checks = 0;
  int errors = 0;
  int tally;

  always #5 clk = ~clk;

  rx_idle_monitor dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_valid    (rx_valid),
    .rx_char     (rx_char),
    .rx_is_k     (rx_is_k),
    .rx_code_err (rx_code_err),
    .lane_up     (lane_up),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .got_K       (got_K),
    .got_A       (got_A),
    .got_R       (got_R),
    .err         (err)
`ifdef RX_IDLE_STATS_EN
    ,
    .err_count   (err_count)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One valid symbol per call; outputs are sampled 1 ns after the edge that took it.
  task automatic send(input logic k, input logic [7:0] ch, input logic cerr);
    @(negedge clk);
    rx_valid    = 1'b1;
    rx_is_k     = k;
    rx_char     = ch;
    rx_code_err = cerr;
    @(posedge clk);
    #1;
    rx_valid    = 1'b0;
    rx_is_k     = 1'b0;
    rx_code_err = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic align();
    do_reset();
    repeat (8) send(1'b1, 8'hBC, 1'b0);
  endtask

  initial begin
    rst_n       = 1'b0;
    rx_valid    = 1'b0;
    rx_char     = 8'h00;
    rx_is_k     = 1'b0;
    rx_code_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lane_up", 16'(lane_up), 16'd0);
    chk("rst_data_valid", 16'(data_valid), 16'd0);
    chk("rst_data_out", 16'(data_out), 16'h00);
    chk("rst_got_k", 16'(got_K), 16'd0);
    chk("rst_err", 16'(err), 16'd0);
`ifdef RX_IDLE_STATS_EN
    chk("rst_err_count", err_count, 16'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // 8 clean /K/: lane_up only after the 8th is taken.
    tally = 0;
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 8'hBC, 1'b0);
      tally += int'(got_K);
      chk("align_lane_up", 16'(lane_up), (i == 7) ? 16'd1 : 16'd0);
    end
    chk("align_got_k_count", 16'(tally), 16'd8);

    // Data passes through while aligned; /K/ then /R/ is a legal idle run.
    send(1'b0, 8'h11, 1'b0);
    chk("data11_out", 16'(data_out), 16'h11);
    chk("data11_valid", 16'(data_valid), 16'd1);
    send(1'b0, 8'h22, 1'b0);
    chk("data22_out", 16'(data_out), 16'h22);
    chk("data22_valid", 16'(data_valid), 16'd1);
    send(1'b1, 8'hBC, 1'b0);
    chk("idle_k_valid", 16'(data_valid), 16'd0);
    chk("idle_k_err", 16'(err), 16'd0);
    send(1'b1, 8'h1C, 1'b0);
    chk("idle_r_got_r", 16'(got_R), 16'd1);
    chk("idle_r_err", 16'(err), 16'd0);

    // No strobe: pulses drop, state holds.
    @(posedge clk);
    #1;
    chk("hold_got_r", 16'(got_R), 16'd0);
    chk("hold_lane_up", 16'(lane_up), 16'd1);

    // /R/ as first idle after data.
    send(1'b0, 8'h33, 1'b0);
    send(1'b1, 8'h1C, 1'b0);
    chk("r_after_data_err", 16'(err), 16'd1);
    chk("r_after_data_lane", 16'(lane_up), 16'd1);
    send(1'b1, 8'hBC, 1'b0);
    chk("r_after_data_next_err", 16'(err), 16'd0);

    // /A/ spacing: /A/ at 0 and 10 (too close), next /A/ 20 later (legal),
    // then 40 /K/ with no /A/: only the 33rd (distance 33 > 32) is flagged.
    align();
    send(1'b1, 8'h7C, 1'b0);
    chk("a0_got_a", 16'(got_A), 16'd1);
    chk("a0_err", 16'(err), 16'd0);
    tally = 0;
    repeat (9) begin
      send(1'b1, 8'hBC, 1'b0);
      tally += int'(err);
    end
    send(1'b1, 8'h7C, 1'b0);
    chk("a_gap10_err", 16'(err), 16'd1);
    repeat (19) begin
      send(1'b1, 8'hBC, 1'b0);
      tally += int'(err);
    end
    send(1'b1, 8'h7C, 1'b0);
    chk("a_gap20_err", 16'(err), 16'd0);
    for (int i = 0; i < 40; i++) begin
      send(1'b1, 8'hBC, 1'b0);
      if (i == 32) chk("a_max_gap_err", 16'(err), 16'd1);
      else tally += int'(err);
    end
    chk("a_spacing_spurious_errs", 16'(tally), 16'd0);
    chk("a_spacing_lane_up", 16'(lane_up), 16'd1);

    // Four code errors inside one window drop the lane.
    align();
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 8'hBC, 1'b1);
      chk("limit_err_pulse", 16'(err), 16'd1);
      chk("limit_lane_up", 16'(lane_up), (i < 3) ? 16'd1 : 16'd0);
    end
`ifdef RX_IDLE_STATS_EN
    chk("limit_err_count", err_count, 16'd4);
`endif
    send(1'b1, 8'hBC, 1'b1);
    chk("hunt_no_err", 16'(err), 16'd0);

    // 3 errors, 60 idles, then an error on the 64th symbol (the wrap) starts
    // the new window at 1: two more keep the lane, a third drops it.
    align();
    repeat (3) send(1'b1, 8'hBC, 1'b1);
    repeat (60) send(1'b1, 8'hBC, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 8'hBC, 1'b1);
      chk("window_lane_up", 16'(lane_up), (i < 3) ? 16'd1 : 16'd0);
    end

    // Data in VERIFY returns to HUNT; a full 8 /K/ are needed again.
    do_reset();
    repeat (3) send(1'b1, 8'hBC, 1'b0);
    send(1'b0, 8'h40, 1'b0);
    chk("verify_data_valid", 16'(data_valid), 16'd0);
    chk("verify_data_err", 16'(err), 16'd0);
    repeat (7) send(1'b1, 8'hBC, 1'b0);
    chk("verify_restart_7", 16'(lane_up), 16'd0);
    send(1'b1, 8'hBC, 1'b0);
    chk("verify_restart_8", 16'(lane_up), 16'd1);

    // Illegal K character while verifying.
    do_reset();
    repeat (2) send(1'b1, 8'hBC, 1'b0);
    send(1'b1, 8'hF7, 1'b0);
    chk("verify_illegal_err", 16'(err), 16'd1);
    chk("verify_illegal_lane", 16'(lane_up), 16'd0);

    // Reset while aligned and receiving data.
    align();
    send(1'b0, 8'h55, 1'b0);
    chk("pre_rst_valid", 16'(data_valid), 16'd1);
    send(1'b1, 8'h1C, 1'b0);
    chk("pre_rst_err", 16'(err), 16'd1);
    @(negedge clk);
    rst_n    = 1'b0;
    rx_valid = 1'b1;
    rx_is_k  = 1'b0;
    rx_char  = 8'h66;
    @(posedge clk);
    #1;
    chk("mid_rst_lane_up", 16'(lane_up), 16'd0);
    chk("mid_rst_valid", 16'(data_valid), 16'd0);
    chk("mid_rst_data_out", 16'(data_out), 16'h00);
`ifdef RX_IDLE_STATS_EN
    chk("mid_rst_err_count", err_count, 16'd0);
`endif
    rx_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 8'h77, 1'b0);
    chk("post_rst_hunt_valid", 16'(data_valid), 16'd0);
    chk("post_rst_hunt_lane", 16'(lane_up), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
